// File: rtl/act_sparse_encoder_if.sv
// rtl/act_sparse_encoder_if.sv - dense row input stream and activation write bus
// The encoder takes the slave side; the feature-map fetch path / memory side takes master.
interface act_sparse_encoder_if #(
  parameter int IF_WIDTH   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NZ_WIDTH   = 5
);
  logic                           in_valid;
  logic                           in_ready;
  logic [IF_WIDTH*DATA_WIDTH-1:0] in_data;
  logic                           wr_stall;
  logic                           wr_req_act_flag;
  logic [IF_WIDTH-1:0]            wr_data_act_flag;
  logic [IF_WIDTH-1:0]            wr_req_act;
  logic [IF_WIDTH*DATA_WIDTH-1:0] wr_data_act;
  logic [NZ_WIDTH-1:0]            row_val_num;

  modport slave (
    input  in_valid, in_data, wr_stall,
    output in_ready, wr_req_act_flag, wr_data_act_flag, wr_req_act, wr_data_act, row_val_num
  );

  modport master (
    output in_valid, in_data, wr_stall,
    input  in_ready, wr_req_act_flag, wr_data_act_flag, wr_req_act, wr_data_act, row_val_num
  );
endinterface

// File: rtl/act_sparse_encoder.sv
// rtl/act_sparse_encoder.sv - frames dense activation rows into flag word + masked lane writes
// Rows pass through a 2-entry FIFO so the write side can stall without losing accepted rows.
module act_sparse_encoder #(
  parameter int IF_WIDTH   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 16,
  parameter int NZ_WIDTH   = 5,
  parameter int TOT_WIDTH  = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  act_sparse_encoder_if.slave  bus,
  output logic [TOT_WIDTH-1:0] frame_nz_cnt,
  output logic                 busy,
  output logic                 done
);
  localparam int ROW_BITS = IF_WIDTH * DATA_WIDTH;
  localparam int CNT_W    = $clog2(ROWS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [IF_WIDTH-1:0] flag;
    logic [ROW_BITS-1:0] data;
    logic [NZ_WIDTH-1:0] pop;
  } entry_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    row_cnt;
  entry_t              mem [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          fifo_cnt;
  logic                fifo_full, fifo_empty;
  logic                in_ready, accept, pop, start_frame;
  entry_t              enc, head;
  logic [DATA_WIDTH-1:0] lane;

  logic                out_strobe;
  logic [IF_WIDTH-1:0] out_flag;
  logic [ROW_BITS-1:0] out_data;
  logic [NZ_WIDTH-1:0] out_pop;

  assign fifo_full   = (fifo_cnt == 2'd2);
  assign fifo_empty  = (fifo_cnt == 2'd0);
  assign in_ready    = (state == S_RUN) && !fifo_full;
  assign accept      = bus.in_valid && in_ready;
  assign pop         = !fifo_empty && !bus.wr_stall;
  assign start_frame = (state == S_IDLE) && start;
  assign head        = mem[rd_ptr];

  // Lane 0 sits in the MSB byte; flag bit i describes lane i.
  always_comb begin
    enc  = '0;
    lane = '0;
    for (int i = 0; i < IF_WIDTH; i++) begin
      lane = bus.in_data[(IF_WIDTH-i)*DATA_WIDTH-1 -: DATA_WIDTH];
      if (lane != '0) begin
        enc.flag[i] = 1'b1;
        enc.data[(IF_WIDTH-i)*DATA_WIDTH-1 -: DATA_WIDTH] = lane;
        enc.pop = enc.pop + NZ_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      row_cnt <= '0;
    end else begin
      state <= next_state;
      if (start_frame)  row_cnt <= '0;
      else if (accept)  row_cnt <= row_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (accept && row_cnt == CNT_W'(ROWS - 1)) next_state = S_DRAIN;
      // An empty FIFO here means the final row was popped into the output stage on the last edge.
      S_DRAIN: if (fifo_empty) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_strobe   <= 1'b0;
      out_flag     <= '0;
      out_data     <= '0;
      out_pop      <= '0;
      frame_nz_cnt <= '0;
    end else begin
      out_strobe <= pop;
      out_flag   <= pop ? head.flag : '0;
      out_data   <= pop ? head.data : '0;
      out_pop    <= pop ? head.pop  : '0;
      if (start_frame) frame_nz_cnt <= '0;
      else if (pop)    frame_nz_cnt <= frame_nz_cnt + TOT_WIDTH'(head.pop);
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.wr_req_act_flag  = out_strobe;
  assign bus.wr_data_act_flag = out_flag;
  assign bus.wr_req_act       = out_flag & {IF_WIDTH{out_strobe}};
  assign bus.wr_data_act      = out_data;
  assign bus.row_val_num      = out_pop;
  assign busy                 = (state != S_IDLE);
  assign done                 = (state == S_DONE);
endmodule

// File: tb/tb_act_sparse_encoder.sv
// tb/tb_act_sparse_encoder.sv - scoreboard bench for act_sparse_encoder
// Driver pushes hand-computed expectations on accept; a negedge monitor pops them on every strobe.
module tb_act_sparse_encoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [8:0] frame_nz_cnt;
  logic       busy, done;

  act_sparse_encoder_if #(.IF_WIDTH(16), .DATA_WIDTH(8), .NZ_WIDTH(5)) bus ();

  act_sparse_encoder #(.IF_WIDTH(16), .DATA_WIDTH(8), .ROWS(16), .NZ_WIDTH(5), .TOT_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .frame_nz_cnt(frame_nz_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  flag;
    logic [127:0] data;
    int           pop;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_frame = 0;
  int strobe_count = 0;
  int last_strobe = -10;
  int prev_strobe = -10;
  int done_count = 0;
  int done_cycle = -10;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        done_count++;
        done_cycle = cyc;
      end
      if (bus.wr_req_act_flag) begin
        exp_t e;
        strobe_count++;
        prev_strobe = last_strobe;
        last_strobe = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          exp_frame += e.pop;
          check("mon_flag", 128'(bus.wr_data_act_flag), 128'(e.flag));
          check("mon_req", 128'(bus.wr_req_act), 128'(e.flag));
          check("mon_data", bus.wr_data_act, e.data);
          check("mon_popcnt", 128'(bus.row_val_num), 128'(e.pop));
          check("mon_frame", 128'(frame_nz_cnt), 128'(exp_frame));
        end
      end else begin
        check("idle_outputs_zero", 128'({bus.wr_req_act, bus.wr_data_act_flag, bus.row_val_num}), 128'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    if (!busy) exp_frame = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_row(input logic [127:0] d, input logic [15:0] f, input int p);
    int t = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("accept_timeout", 128'(0), 128'(1));
    else exp_q.push_back('{flag: f, data: d, pop: p});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    exp_q.delete();
    exp_frame = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] ROW_A   = 128'h050000FF_00000000_00000000_00000080;
  localparam logic [127:0] ROW_11  = {16{8'h11}};
  localparam logic [127:0] ROW_P   = 128'h01020304_05000000_00000000_00000000;
  localparam logic [127:0] ROW_Q   = 128'h00000000_00000000_000000AA_BBCCDDEE;

  initial begin
    logic [127:0] sd [4];
    logic [15:0]  sf [4];
    int s0, d0, idx, acc;
    sd[0] = 128'h7F000000_00000000_00000000_00000000; sf[0] = 16'h0001;
    sd[1] = 128'h007F0000_00000000_00000000_00000000; sf[1] = 16'h0002;
    sd[2] = 128'h00007F00_00000000_00000000_00000000; sf[2] = 16'h0004;
    sd[3] = 128'h0000007F_00000000_00000000_00000000; sf[3] = 16'h0008;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wr_stall = 1'b0;
    #12;
    check("rst_outputs", 128'({bus.wr_req_act_flag, bus.wr_data_act_flag, bus.wr_req_act, bus.row_val_num}), 128'(0));
    check("rst_state", 128'({bus.in_ready, busy, done, frame_nz_cnt}), 128'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // reset during RUN with two rows buffered behind a stall
    pulse_start();
    bus.wr_stall = 1'b1;
    send_row(sd[0], sf[0], 1);
    send_row(sd[1], sf[1], 1);
    @(negedge clk);
    check("buffered_full_ready", 128'(bus.in_ready), 128'(0));
    s0 = strobe_count; d0 = done_count;
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_frame = 0;
    #1;
    check("midrst_outputs", 128'({bus.wr_req_act_flag, bus.wr_data_act_flag, bus.wr_req_act, bus.wr_data_act}), 128'(0));
    check("midrst_state", 128'({bus.in_ready, busy, done, frame_nz_cnt, bus.row_val_num}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.wr_stall = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_strobe", 128'(strobe_count - s0), 128'(0));
    check("midrst_no_done", 128'(done_count - d0), 128'(0));
    @(posedge clk); #1;

    // single sparse row: two-cycle accept-to-strobe
    pulse_start();
    send_row(ROW_A, 16'h8009, 3);
    check("lat_edge_n", 128'(bus.wr_req_act_flag), 128'(0));
    @(posedge clk); #1;
    check("lat_strobe", 128'(bus.wr_req_act_flag), 128'(1));
    check("lat_flag", 128'(bus.wr_data_act_flag), 128'(16'h8009));
    check("lat_req", 128'(bus.wr_req_act), 128'(16'h8009));
    check("lat_popcnt", 128'(bus.row_val_num), 128'(3));
    check("lat_frame", 128'(frame_nz_cnt), 128'(3));
    do_reset();

    // all-zero row then all-0x11 row back-to-back
    pulse_start();
    s0 = strobe_count;
    send_row(128'h0, 16'h0000, 0);
    send_row(ROW_11, 16'hFFFF, 16);
    repeat (4) @(negedge clk);
    check("b2b_strobes", 128'(strobe_count - s0), 128'(2));
    check("b2b_consecutive", 128'(last_strobe - prev_strobe), 128'(1));
    check("b2b_frame", 128'(frame_nz_cnt), 128'(16));
    do_reset();

    // stall with in_valid held: only two rows fit
    pulse_start();
    bus.wr_stall = 1'b1;
    s0 = strobe_count;
    idx = 0; acc = 0;
    bus.in_data = sd[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      logic took;
      @(negedge clk);
      took = bus.in_ready && idx < 4;
      if (took) begin
        exp_q.push_back('{flag: sf[idx], data: sd[idx], pop: 1});
        acc++;
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        bus.in_data = sd[idx];
      end
    end
    @(negedge clk);
    check("stall_accepts", 128'(acc), 128'(2));
    check("stall_ready_low", 128'(bus.in_ready), 128'(0));
    check("stall_no_strobe", 128'(strobe_count - s0), 128'(0));
    @(posedge clk); #1;
    bus.wr_stall = 1'b0;
    @(posedge clk); #1;
    check("release_strobe1", 128'(bus.wr_req_act_flag), 128'(1));
    @(negedge clk);
    check("release_ready", 128'(bus.in_ready), 128'(1));
    exp_q.push_back('{flag: sf[2], data: sd[2], pop: 1});
    @(posedge clk); #1;
    check("release_strobe2", 128'(bus.wr_req_act_flag), 128'(1));
    bus.in_data = sd[3];
    @(negedge clk);
    if (bus.in_ready) exp_q.push_back('{flag: sf[3], data: sd[3], pop: 1});
    else check("release_ready2", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_total_strobes", 128'(strobe_count - s0), 128'(4));
    check("stall_frame", 128'(frame_nz_cnt), 128'(4));
    do_reset();

    // full frame with start pulses in RUN and DRAIN
    pulse_start();
    d0 = done_count;
    for (int r = 0; r < 16; r++) begin
      if (r == 5) start = 1'b1;
      if (r[0]) send_row(ROW_Q, 16'hF800, 5);
      else      send_row(ROW_P, 16'h001F, 5);
      start = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
    check("frame_done_once", 128'(done_count - d0), 128'(1));
    check("frame_done_timing", 128'(done_cycle - last_strobe), 128'(1));
    check("frame_total", 128'(frame_nz_cnt), 128'(80));
    check("frame_idle", 128'(busy), 128'(0));
    repeat (5) @(negedge clk);
    check("frame_hold_total", 128'(frame_nz_cnt), 128'(80));
    check("frame_no_extra_done", 128'(done_count - d0), 128'(1));
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/act_sparse_encoder.md
Name: act_sparse_encoder

Overview:
- Producer side of the mem_controller activation write interface.
- Takes dense activation rows of IF_WIDTH bytes. For each row it generates the nonzero flag word and drives wr_req_act_flag / wr_data_act_flag / wr_req_act / wr_data_act with that flag word and the lane data.
- Sits between the feature-map fetch path and mem_controller. It frames ROWS rows per start, buffers through a 2-entry FIFO under backpressure, and reports per-row and per-frame nonzero counts.

Parameters:
- IF_WIDTH, 16, lanes per row and width of the flag word.
- DATA_WIDTH, 8, bits per activation lane.
- ROWS, 16, rows per frame.
- NZ_WIDTH, 5, width of row_val_num (holds 0..IF_WIDTH).
- TOT_WIDTH, 9, width of frame_nz_cnt (holds 0..ROWS*IF_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when the block is in IDLE.
- in_valid  in  1  a dense row is present on in_data.
- in_ready  out  1  the block accepts the row this cycle.
- in_data  in  IF_WIDTH*DATA_WIDTH  dense row; lane i = in_data[(IF_WIDTH-i)*DATA_WIDTH-1 -: DATA_WIDTH], so lane 0 is the MSB byte.
- wr_stall  in  1  downstream backpressure; no row is emitted while high.
- wr_req_act_flag  out  1  flag-write strobe.
- wr_data_act_flag  out  IF_WIDTH  flag word; bit i = (lane i != 0).
- wr_req_act  out  IF_WIDTH  per-lane write request; equals wr_data_act_flag while the strobe is high, 0 otherwise.
- wr_data_act  out  IF_WIDTH*DATA_WIDTH  lane data with the same lane order; a lane is forced to 0 when its flag bit is 0.
- row_val_num  out  NZ_WIDTH  popcount of the emitted flag word.
- frame_nz_cnt  out  TOT_WIDTH  running nonzero total for the current frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, FIFO emptied, row counter=0, frame_nz_cnt=0.
  - All outputs are 0; in_ready=0.
  - A reset in the middle of a frame discards buffered rows; no done pulse is produced.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE: in_ready=0. start=1 → RUN; the row counter and frame_nz_cnt are cleared on the same edge.
  - RUN: in_ready = !fifo_full. A row is accepted on an edge where in_valid & in_ready; the row counter increments. When the ROWS-th row is accepted → DRAIN, and in_ready drops in the following cycle.
  - DRAIN: in_ready=0. When the FIFO is empty and the output stage has issued the last row → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - start outside IDLE is ignored. in_valid outside RUN is ignored.
- Encode (at accept):
  - Flag and popcount are computed combinationally from in_data.
  - {flag, masked data, popcount} is written into the FIFO (depth 2).
- Output stage (registered):
  - On each edge, if the FIFO is non-empty and wr_stall=0: pop the head, drive wr_req_act_flag=1, wr_data_act_flag=flag, wr_req_act=flag, wr_data_act=data, row_val_num=popcount, and add popcount to frame_nz_cnt.
  - Otherwise the strobe, wr_req_act, wr_data_act_flag, wr_data_act and row_val_num are driven to 0.
  - Latency: a row accepted at edge N with wr_stall low appears after edge N+1 (two-cycle accept-to-strobe).
  - Strobes on consecutive cycles are allowed (one row per cycle sustained).
- FIFO boundaries:
  - A push and a pop on the same edge are legal at any occupancy below full; occupancy is unchanged.
  - When full, in_ready=0, so no push occurs. A pop while full frees one entry, and in_ready rises on the next cycle.
  - Pop from empty never occurs.
- An all-zero row is still emitted: strobe=1, flag=0, wr_req_act=0, row_val_num=0.
- frame_nz_cnt holds its value through DONE and IDLE until the next start clears it. Maximum is 256, no wrap with the default widths.

Test Plan:
- Reset during RUN with 2 rows buffered → all outputs 0 immediately. No strobe and no done afterwards. A new start resumes normally.
- Row with lane0=0x05, lane3=0xFF, lane15=0x80, all other lanes 0, accepted at edge N → after edge N+1: wr_req_act_flag=1, wr_data_act_flag=16'h8009, wr_req_act=16'h8009, row_val_num=3, frame_nz_cnt=3.
- All-zero row then all-0x11 row back-to-back → strobes on consecutive cycles with flags 16'h0000 then 16'hFFFF, row_val_num 0 then 16, frame_nz_cnt 16.
- wr_stall=1 for 6 cycles while in_valid is held high → exactly 2 rows accepted, then in_ready=0 and no strobes. Release stall → strobes on the next 2 edges, in_ready returns, and no row is lost or duplicated.
- Full frame of 16 rows with 5 nonzero lanes each, no stall:
  - done pulses exactly once, 1 cycle after the last strobe (DONE is reached on the edge after the last strobe; done is high in that cycle).
  - frame_nz_cnt=80; busy falls with IDLE on the edge after done.
- start pulsed again in RUN and in DRAIN → ignored; row count and frame_nz_cnt are unaffected, and done fires once at 16 rows.
